// File: rtl/imul_iter.sv
// Iterative shift-add multiplier for the tinyrv1 X stage: one partial product per cycle.
// Optional IMUL_EARLY_EXIT_EN ends CALC once the remaining multiplier bits are all zero.
module imul_iter #(
    parameter int nbits = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [nbits-1:0] in0,
    input  logic [nbits-1:0] in1,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [nbits-1:0] out
);

    localparam int cw = $clog2(nbits) + 1;
    localparam logic [cw-1:0] last_cnt = cw'(nbits - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [nbits-1:0] a;
    logic [nbits-1:0] b;
    logic [nbits-1:0] acc;
    logic [cw-1:0]    cnt;
    logic             calc_last;

    always_comb begin
        calc_last = (cnt == last_cnt);
`ifdef IMUL_EARLY_EXIT_EN
        // Nothing left to add once the shifted multiplier is empty.
        if ((b >> 1) == '0) begin
            calc_last = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (istream_val) begin
                        a     <= in0;
                        b     <= in1;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (b[0]) begin
                        acc <= acc + a;
                    end
                    a   <= a << 1;
                    b   <= b >> 1;
                    cnt <= cnt + cw'(1);
                    if (calc_last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (ostream_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags are masked while rst is high so no transfer is offered during reset.
    assign istream_rdy = (state == IDLE) && !rst;
    assign ostream_val = (state == DONE) && !rst;
    assign out         = acc;

endmodule
